cascade_counter: RTL and testbench

CASCADE_COUNTER -- requirements
Module: cascade_counter

---
 rtl/cascade_counter.sv | 121 ++++++++++++
 tb/tb_cascade_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cascade_counter.sv
// cascade_counter
//   Two-stage up/down modulo counter. Stage 0 counts modulo MOD0 while en is
//   high. Stage 1 counts modulo MOD1 and advances only through a clock enable
//   driven by the stage-0 terminal count. No derived clocks are used.
//   Control priority is clr, then load, then en. Load values above MOD-1
//   are clamped to MOD-1.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous active-low reset
//   en         stage-0 count enable
//   up_dn      count direction, 1 = up, 0 = down
//   clr        synchronous clear of both stages
//   load       synchronous load of both stages
//   load_val0  stage-0 load value (clamped to MOD0-1)
//   load_val1  stage-1 load value (clamped to MOD1-1)
//   count_0    registered stage-0 count
//   count_1    registered stage-1 count
//   tc0        combinational stage-0 terminal-count pulse
//   tc1        combinational cascade terminal-count pulse
//   clk_div0   registered divide-by-MOD0 waveform
//   clk_div1   registered divide-by-(MOD0*MOD1) waveform
module cascade_counter #(
    parameter int MOD0 = 50,
    parameter int W0   = 6,
    parameter int MOD1 = 10,
    parameter int W1   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          up_dn,
    input  logic          clr,
    input  logic          load,
    input  logic [W0-1:0] load_val0,
    input  logic [W1-1:0] load_val1,
    output logic [W0-1:0] count_0,
    output logic [W1-1:0] count_1,
    output logic          tc0,
    output logic          tc1,
    output logic          clk_div0,
    output logic          clk_div1
);

    localparam logic [W0-1:0] MAX0  = W0'(MOD0 - 1);
    localparam logic [W1-1:0] MAX1  = W1'(MOD1 - 1);
    localparam logic [W0-1:0] HALF0 = W0'(MOD0 / 2);
    localparam logic [W1-1:0] HALF1 = W1'(MOD1 / 2);

    // Saturate an out-of-range load value to MOD0-1.
    function automatic logic [W0-1:0] clamp0(input logic [W0-1:0] v);
        return (v > MAX0) ? MAX0 : v;
    endfunction

    // Saturate an out-of-range load value to MOD1-1.
    function automatic logic [W1-1:0] clamp1(input logic [W1-1:0] v);
        return (v > MAX1) ? MAX1 : v;
    endfunction

    // One modulo-MOD0 step in the requested direction.
    function automatic logic [W0-1:0] step0(input logic [W0-1:0] c, input logic up);
        if (up)
            return (c == MAX0) ? '0 : c + W0'(1);
        else
            return (c == '0) ? MAX0 : c - W0'(1);
    endfunction

    // One modulo-MOD1 step in the requested direction.
    function automatic logic [W1-1:0] step1(input logic [W1-1:0] c, input logic up);
        if (up)
            return (c == MAX1) ? '0 : c + W1'(1);
        else
            return (c == '0) ? MAX1 : c - W1'(1);
    endfunction

    logic [W0-1:0] nxt0;
    logic [W1-1:0] nxt1;
    logic          at_end0;
    logic          at_end1;

    assign at_end0 = (count_0 == (up_dn ? MAX0 : '0));
    assign at_end1 = (count_1 == (up_dn ? MAX1 : '0));

    // rst is folded in so the pulses stay low while reset is held, even when
    // the reset value 0/0 is the terminal value of a down count.
    assign tc0 = rst & en & ~clr & ~load & at_end0;
    assign tc1 = tc0 & at_end1;

    always_comb begin
        nxt0 = count_0;
        nxt1 = count_1;
        if (clr) begin
            nxt0 = '0;
            nxt1 = '0;
        end else if (load) begin
            nxt0 = clamp0(load_val0);
            nxt1 = clamp1(load_val1);
        end else if (en) begin
            nxt0 = step0(count_0, up_dn);
            if (tc0)
                nxt1 = step1(count_1, up_dn);
        end
    end

    // clk_div* are computed from the next count so they stay aligned with
    // the registered count they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_0  <= '0;
            count_1  <= '0;
            clk_div0 <= 1'b0;
            clk_div1 <= 1'b0;
        end else begin
            count_0  <= nxt0;
            count_1  <= nxt1;
            clk_div0 <= (nxt0 >= HALF0);
            clk_div1 <= (nxt1 >= HALF1);
        end
    end

endmodule

// File: tb/tb_cascade_counter.sv
// Testbench for cascade_counter. Two instances share control inputs: one
// with default parameters (50 x 10) and one small (5 x 3). The reference
// model treats each cascade as one mixed-radix position v in 0..MOD0*MOD1-1
// that moves by +/-1 modulo MOD0*MOD1; the digits are v%MOD0 and v/MOD0.
module tb_cascade_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up_dn, clr, load;
    logic [5:0] a_lv0;
    logic [3:0] a_lv1;
    logic [2:0] b_lv0;
    logic [1:0] b_lv1;
    logic [5:0] a_c0;
    logic [3:0] a_c1;
    logic [2:0] b_c0;
    logic [1:0] b_c1;
    logic       a_tc0, a_tc1, a_d0, a_d1;
    logic       b_tc0, b_tc1, b_d0, b_d1;

    int n_chk  = 0;
    int n_pass = 0;
    int va = 0;
    int vb = 0;

    always #5 clk = ~clk;

    cascade_counter dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val0(a_lv0), .load_val1(a_lv1),
        .count_0(a_c0), .count_1(a_c1), .tc0(a_tc0), .tc1(a_tc1),
        .clk_div0(a_d0), .clk_div1(a_d1)
    );

    cascade_counter #(.MOD0(5), .W0(3), .MOD1(3), .W1(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val0(b_lv0), .load_val1(b_lv1),
        .count_0(b_c0), .count_1(b_c1), .tc0(b_tc0), .tc1(b_tc1),
        .clk_div0(b_d0), .clk_div1(b_d1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Next position of the cascade after one edge.
    function automatic int m_next(input int v, input int m0, input int m1,
                                  input bit c, input bit l, input bit e, input bit u,
                                  input int l0, input int l1);
        int n = m0 * m1;
        if (c) return 0;
        if (l) return min2(l1, m1 - 1) * m0 + min2(l0, m0 - 1);
        if (e) return u ? (v + 1) % n : (v + n - 1) % n;
        return v;
    endfunction

    function automatic int m_tc0(input int v, input int m0, input bit c, input bit l,
                                 input bit e, input bit u);
        return (e && !c && !l && ((v % m0) == (u ? m0 - 1 : 0))) ? 1 : 0;
    endfunction

    function automatic int m_tc1(input int v, input int m0, input int m1, input bit c,
                                 input bit l, input bit e, input bit u);
        return (e && !c && !l && (v == (u ? m0 * m1 - 1 : 0))) ? 1 : 0;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, " a_count_0"}, int'(a_c0), va % 50);
        chk({tag, " a_count_1"}, int'(a_c1), va / 50);
        chk({tag, " a_clk_div0"}, int'(a_d0), ((va % 50) >= 25) ? 1 : 0);
        chk({tag, " a_clk_div1"}, int'(a_d1), ((va / 50) >= 5) ? 1 : 0);
        chk({tag, " b_count_0"}, int'(b_c0), vb % 5);
        chk({tag, " b_count_1"}, int'(b_c1), vb / 5);
        chk({tag, " b_clk_div0"}, int'(b_d0), ((vb % 5) >= 2) ? 1 : 0);
        chk({tag, " b_clk_div1"}, int'(b_d1), ((vb / 5) >= 1) ? 1 : 0);
    endtask

    // Drive one cycle of inputs, check the combinational pulses, take the
    // edge and check the registered state.
    task automatic step(input string tag, input bit c, input bit l, input bit e,
                        input bit u, input int al0, input int al1,
                        input int bl0, input int bl1);
        clr = c; load = l; en = e; up_dn = u;
        a_lv0 = 6'(al0); a_lv1 = 4'(al1);
        b_lv0 = 3'(bl0); b_lv1 = 2'(bl1);
        #1;
        chk({tag, " a_tc0"}, int'(a_tc0), m_tc0(va, 50, c, l, e, u));
        chk({tag, " a_tc1"}, int'(a_tc1), m_tc1(va, 50, 10, c, l, e, u));
        chk({tag, " b_tc0"}, int'(b_tc0), m_tc0(vb, 5, c, l, e, u));
        chk({tag, " b_tc1"}, int'(b_tc1), m_tc1(vb, 5, 3, c, l, e, u));
        va = m_next(va, 50, 10, c, l, e, u, int'(a_lv0), int'(a_lv1));
        vb = m_next(vb, 5, 3, c, l, e, u, int'(b_lv0), int'(b_lv1));
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        va = 0; vb = 0;
        check_state("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    int tc0_hits;
    int tc1_hits;

    initial begin
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        a_lv0 = '0; a_lv1 = '0; b_lv0 = '0; b_lv1 = '0;
        #1;
        chk("reset a_tc0", int'(a_tc0), 0);
        do_reset();

        // Free-running up count for 500 cycles from reset.
        tc0_hits = 0; tc1_hits = 0;
        for (int i = 1; i <= 500; i++) begin
            clr = 0; load = 0; en = 1; up_dn = 1;
            #1;
            if (a_tc0) tc0_hits++;
            if (a_tc1) begin
                tc1_hits++;
                chk("tc1 cycle index", i, 500);
            end
            step("up500", 0, 0, 1, 1, 0, 0, 0, 0);
        end
        chk("tc0 count in 500", tc0_hits, 10);
        chk("tc1 count in 500", tc1_hits, 1);
        chk("count_1 wrapped", int'(a_c1), 0);

        // Down count from reset wraps both stages on the first edge.
        do_reset();
        #1;
        en = 1; up_dn = 0;
        #1;
        chk("down tc1 at 0/0", int'(a_tc1), 1);
        step("down1", 0, 0, 1, 0, 0, 0, 0, 0);
        chk("down 0 -> 49", int'(a_c0), 49);
        chk("down 0 -> 9", int'(a_c1), 9);

        // Clamped load, then an up step through the cascade wrap.
        step("load63", 0, 1, 1, 1, 63, 12, 7, 3);
        chk("load clamp c0", int'(a_c0), 49);
        chk("load clamp c1", int'(a_c1), 9);
        step("after load", 0, 0, 1, 1, 0, 0, 0, 0);

        // clr beats load and en.
        step("load17", 0, 1, 0, 1, 17, 3, 2, 1);
        step("clr+load+en", 1, 1, 1, 1, 40, 5, 3, 2);
        chk("clr wins c0", int'(a_c0), 0);

        // Asynchronous reset between edges at count 33/7.
        step("load33", 0, 1, 0, 1, 33, 7, 4, 2);
        clr = 0; load = 0; en = 1; up_dn = 0;
        #2;
        rst = 1'b0;
        #1;
        va = 0; vb = 0;
        check_state("async rst");
        chk("async rst a_tc0", int'(a_tc0), 0);
        chk("async rst b_tc1", int'(b_tc1), 0);
        rst = 1'b1;
        step("post rst", 0, 0, 1, 1, 0, 0, 0, 0);
        chk("post rst c0", int'(a_c0), 1);

        // Randomized mix of all controls.
        for (int i = 0; i < 2000; i++) begin
            step("rand",
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 8),
                 (i % 300 < 150) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
